// File: rtl/puzzle_mover.sv
// puzzle_mover: command-driven move engine for the 4x4 sliding-puzzle board memory.
// Define MOVER_SOLVED_CHECK_EN to re-scan the board for the solved layout after every legal move.
module puzzle_mover #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    output logic               done,
    output logic               err,
    output logic               solved,
    output logic [COUNT_W-1:0] move_count,
    output logic [3:0]         blank_pos,
    output logic [3:0]         mem_addr,
    output logic               mem_we,
    output logic [3:0]         mem_wdata,
    input  logic [3:0]         mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RD,
        S_WR_BLANK,
        S_WR_TGT,
`ifdef MOVER_SOLVED_CHECK_EN
        S_CHECK,
`endif
        S_DONE
    } state_e;

    localparam logic [2:0] OP_UP    = 3'd0;
    localparam logic [2:0] OP_DOWN  = 3'd1;
    localparam logic [2:0] OP_LEFT  = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_INIT  = 3'd4;

    state_e             state_q;
    logic               cmd_ready_q;
    logic               done_q;
    logic               err_q;
    logic               solved_q;
    logic [COUNT_W-1:0] move_count_q;
    logic [3:0]         blank_pos_q;
    logic [3:0]         target_q;
    logic [3:0]         idx_q;
    logic [3:0]         mem_addr_q;
    logic               mem_we_q;
    logic [3:0]         mem_wdata_q;
`ifdef MOVER_SOLVED_CHECK_EN
    logic               all_ok_q;
`endif

    logic [3:0] target_d;
    logic       legal_d;

    // Solved layout: cell i holds tile i+1, the last cell holds the blank (0).
    function automatic logic [3:0] solved_val(input logic [3:0] i);
        return (i == 4'd15) ? 4'd0 : i + 4'd1;
    endfunction

    // Target cell and legality of the requested move; row = pos[3:2], col = pos[1:0].
    always_comb begin
        target_d = blank_pos_q;
        legal_d  = 1'b0;
        case (cmd_op)
            OP_UP: begin
                target_d = blank_pos_q - 4'd4;
                legal_d  = (blank_pos_q[3:2] != 2'd0);
            end
            OP_DOWN: begin
                target_d = blank_pos_q + 4'd4;
                legal_d  = (blank_pos_q[3:2] != 2'd3);
            end
            OP_LEFT: begin
                target_d = blank_pos_q - 4'd1;
                legal_d  = (blank_pos_q[1:0] != 2'd0);
            end
            OP_RIGHT: begin
                target_d = blank_pos_q + 4'd1;
                legal_d  = (blank_pos_q[1:0] != 2'd3);
            end
            default: ;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            solved_q     <= 1'b0;
            move_count_q <= '0;
            blank_pos_q  <= 4'd15;
            target_q     <= '0;
            idx_q        <= '0;
            mem_addr_q   <= 4'd15;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
`ifdef MOVER_SOLVED_CHECK_EN
            all_ok_q     <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_op == OP_INIT) begin
                            state_q     <= S_INIT;
                            err_q       <= 1'b0;
                            idx_q       <= '0;
                            mem_addr_q  <= '0;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= solved_val(4'd0);
                        end else if (legal_d) begin
                            state_q    <= S_RD;
                            err_q      <= 1'b0;
                            target_q   <= target_d;
                            mem_addr_q <= target_d;
                        end else begin
                            state_q <= S_DONE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (idx_q == 4'd15) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_wdata_q  <= '0;
                        mem_addr_q   <= 4'd15;
                        blank_pos_q  <= 4'd15;
                        move_count_q <= '0;
                        solved_q     <= 1'b1;
                    end else begin
                        idx_q       <= idx_q + 4'd1;
                        mem_addr_q  <= idx_q + 4'd1;
                        mem_wdata_q <= solved_val(idx_q + 4'd1);
                    end
                end
                S_RD: begin
                    // The tile read from the target goes straight into the write-data register.
                    state_q     <= S_WR_BLANK;
                    mem_addr_q  <= blank_pos_q;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= mem_rdata;
                end
                S_WR_BLANK: begin
                    state_q     <= S_WR_TGT;
                    mem_addr_q  <= target_q;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= '0;
                end
                S_WR_TGT: begin
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    blank_pos_q <= target_q;
                    if (move_count_q != '1) move_count_q <= move_count_q + COUNT_W'(1);
`ifdef MOVER_SOLVED_CHECK_EN
                    state_q    <= S_CHECK;
                    idx_q      <= '0;
                    mem_addr_q <= '0;
                    all_ok_q   <= 1'b1;
`else
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                    solved_q   <= 1'b0;
                    mem_addr_q <= target_q;
`endif
                end
`ifdef MOVER_SOLVED_CHECK_EN
                S_CHECK: begin
                    if (mem_rdata != solved_val(idx_q)) all_ok_q <= 1'b0;
                    if (idx_q == 4'd15) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        solved_q   <= all_ok_q && (mem_rdata == solved_val(idx_q));
                        mem_addr_q <= blank_pos_q;
                    end else begin
                        idx_q      <= idx_q + 4'd1;
                        mem_addr_q <= idx_q + 4'd1;
                    end
                end
`endif
                S_DONE: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    mem_addr_q  <= blank_pos_q;
                end
                default: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_addr_q  <= blank_pos_q;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign solved     = solved_q;
    assign move_count = move_count_q;
    assign blank_pos  = blank_pos_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_puzzle_mover.sv
// Directed testbench for puzzle_mover with a behavioural 16x4 board memory model.
// Expected latencies and post-move solved state follow MOVER_SOLVED_CHECK_EN.
module tb_puzzle_mover;

    localparam int COUNT_W = 16;
`ifdef MOVER_SOLVED_CHECK_EN
    localparam int MOVE_LAT    = 20;
    localparam int SOLVED_BACK = 1;
    localparam int RST_CYCLE   = 5;
`else
    localparam int MOVE_LAT    = 4;
    localparam int SOLVED_BACK = 0;
    localparam int RST_CYCLE   = 2;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic               done;
    logic               err;
    logic               solved;
    logic [COUNT_W-1:0] move_count;
    logic [3:0]         blank_pos;
    logic [3:0]         mem_addr;
    logic               mem_we;
    logic [3:0]         mem_wdata;
    logic [3:0]         mem_rdata;

    logic [3:0] mem [16];
    int         we_pulses = 0;
    int         n_checks  = 0;
    int         n_fail    = 0;

    puzzle_mover #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .done       (done),
        .err        (err),
        .solved     (solved),
        .move_count (move_count),
        .blank_pos  (blank_pos),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Board memory: combinational read, write at the edge ending the write cycle, cleared by rst_n.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_pulses     <= we_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; returns at the falling edge of the done cycle.
    task automatic issue(input logic [2:0] op, input bit hold, output int lat);
        check("ready_at_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        lat = 1;
        if (!hold) cmd_valid = 1'b0;
        while (!done && lat < 100) begin
            if (hold) check("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int pulses_before;
    logic any_nonzero;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_solved", {31'd0, solved}, 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_blank", {28'd0, blank_pos}, 32'd15);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {28'd0, mem_addr}, 32'd15);
        check("rst_wdata", {28'd0, mem_wdata}, 32'd0);

        // INIT
        issue(3'd4, 1'b0, lat);
        check("init_lat", 32'(lat), 32'd17);
        check("init_err", {31'd0, err}, 32'd0);
        check("init_blank", {28'd0, blank_pos}, 32'd15);
        check("init_count", 32'(move_count), 32'd0);
        check("init_solved", {31'd0, solved}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            check($sformatf("init_cell%0d", i), {28'd0, mem[i]}, (i == 15) ? 32'd0 : 32'(i + 1));

        // Illegal down from row 3
        pulses_before = we_pulses;
        issue(3'd1, 1'b0, lat);
        check("down_lat", 32'(lat), 32'd1);
        check("down_err", {31'd0, err}, 32'd1);
        check("down_no_writes", 32'(we_pulses), 32'(pulses_before));
        check("down_blank", {28'd0, blank_pos}, 32'd15);
        check("down_count", 32'(move_count), 32'd0);
        @(negedge clk);
        check("err_holds", {31'd0, err}, 32'd1);

        // Up: tile 12 slides down into cell 15
        issue(3'd0, 1'b0, lat);
        check("up_lat", 32'(lat), 32'(MOVE_LAT));
        check("up_err", {31'd0, err}, 32'd0);
        check("up_blank", {28'd0, blank_pos}, 32'd11);
        check("up_count", 32'(move_count), 32'd1);
        check("up_solved", {31'd0, solved}, 32'd0);
        check("up_cell11", {28'd0, mem[11]}, 32'd0);
        check("up_cell15", {28'd0, mem[15]}, 32'd12);
        @(negedge clk);

        // Down: back to the solved layout
        issue(3'd1, 1'b0, lat);
        check("down2_lat", 32'(lat), 32'(MOVE_LAT));
        check("down2_blank", {28'd0, blank_pos}, 32'd15);
        check("down2_count", 32'(move_count), 32'd2);
        check("down2_solved", {31'd0, solved}, 32'(SOLVED_BACK));
        check("down2_cell11", {28'd0, mem[11]}, 32'd12);
        check("down2_cell15", {28'd0, mem[15]}, 32'd0);
        @(negedge clk);

        // INIT, then left three times to column 0
        issue(3'd4, 1'b0, lat);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            issue(3'd2, 1'b0, lat);
            check($sformatf("left%0d_err", k), {31'd0, err}, 32'd0);
            check($sformatf("left%0d_blank", k), {28'd0, blank_pos}, 32'(15 - k));
            @(negedge clk);
        end
        check("left3_count", 32'(move_count), 32'd3);
        check("left3_cell12", {28'd0, mem[12]}, 32'd0);
        check("left3_cell13", {28'd0, mem[13]}, 32'd13);
        check("left3_cell15", {28'd0, mem[15]}, 32'd15);
        issue(3'd2, 1'b0, lat);
        check("left4_lat", 32'(lat), 32'd1);
        check("left4_err", {31'd0, err}, 32'd1);
        check("left4_count", 32'(move_count), 32'd3);
        check("left4_blank", {28'd0, blank_pos}, 32'd12);
        @(negedge clk);

        // Right with cmd_valid held through the whole busy period
        issue(3'd3, 1'b1, lat);
        check("hold_lat", 32'(lat), 32'(MOVE_LAT));
        check("hold_count", 32'(move_count), 32'd4);
        check("hold_blank", {28'd0, blank_pos}, 32'd13);
        @(negedge clk);
        @(negedge clk);
        check("hold_no_requeue_done", {31'd0, done}, 32'd0);
        check("hold_no_requeue_cnt", 32'(move_count), 32'd4);

        // Reserved op
        issue(3'd6, 1'b0, lat);
        check("rsvd_lat", 32'(lat), 32'd1);
        check("rsvd_err", {31'd0, err}, 32'd1);
        check("rsvd_count", 32'(move_count), 32'd4);
        @(negedge clk);

        // Reset mid-move
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (RST_CYCLE - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_count", 32'(move_count), 32'd0);
        check("midrst_blank", {28'd0, blank_pos}, 32'd15);
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        any_nonzero = 1'b0;
        for (int i = 0; i < 16; i++) if (mem[i] != 4'd0) any_nonzero = 1'b1;
        check("midrst_board_zero", {31'd0, any_nonzero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd4, 1'b0, lat);
        check("reinit_lat", 32'(lat), 32'd17);
        check("reinit_solved", {31'd0, solved}, 32'd1);
        @(negedge clk);
        check("reinit_cell5", {28'd0, mem[5]}, 32'd6);
        check("reinit_cell15", {28'd0, mem[15]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
